// File: rtl/ysyx_24100006_alu_arb.sv
// Two-port arbiter in front of one shared combinational ALU, with a one-entry registered response slot.
// Define YSYX_24100006_ALU_ARB_FIXED_PRI_EN to make port 0 always win conflicts; default is round-robin.
//
// state | meaning
// EMPTY | no response held, resp_valid=0
// FULL  | response held in the slot, resp_valid=1
module ysyx_24100006_alu_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs_data,
  input  logic [31:0] req0_rt_data,
  input  logic [3:0]  req0_aluop,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs_data,
  input  logic [31:0] req1_rt_data,
  input  logic [3:0]  req1_aluop,
  output logic [31:0] alu_rs_data,
  output logic [31:0] alu_rt_data,
  output logic [3:0]  alu_aluop,
  input  logic [31:0] alu_result,
  input  logic        alu_of,
  input  logic        alu_cf,
  input  logic        alu_zf,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_of,
  output logic        resp_cf,
  output logic        resp_zf,
  input  logic        resp_ready,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;
  logic   slot_free;
  logic   gnt0, gnt1;

`ifndef YSYX_24100006_ALU_ARB_FIXED_PRI_EN
  logic   prio_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    // Reset blocks acceptance so nothing is granted into a slot being cleared.
    slot_free = !reset && ((state_q == EMPTY) || resp_ready);
`ifdef YSYX_24100006_ALU_ARB_FIXED_PRI_EN
    gnt0 = slot_free && req0_valid;
    gnt1 = slot_free && req1_valid && !req0_valid;
`else
    gnt0 = slot_free && req0_valid && (!req1_valid || !prio_q);
    gnt1 = slot_free && req1_valid && (!req0_valid ||  prio_q);
`endif
    if (gnt0 || gnt1)
      state_d = FULL;
    else if (state_q == FULL && resp_ready)
      state_d = EMPTY;
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign alu_rs_data = gnt1 ? req1_rs_data : req0_rs_data;
  assign alu_rt_data = gnt1 ? req1_rt_data : req0_rt_data;
  assign alu_aluop   = gnt1 ? req1_aluop   : req0_aluop;
  assign resp_valid  = (state_q == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id     <= 1'b0;
      resp_result <= 32'd0;
      resp_of     <= 1'b0;
      resp_cf     <= 1'b0;
      resp_zf     <= 1'b0;
    end else if (gnt0 || gnt1) begin
      resp_id     <= gnt1;
      resp_result <= alu_result;
      resp_of     <= alu_of;
      resp_cf     <= alu_cf;
      resp_zf     <= alu_zf;
    end
  end

`ifndef YSYX_24100006_ALU_ARB_FIXED_PRI_EN
  // Pointer favours the port that lost the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)     prio_q <= 1'b0;
    else if (gnt0) prio_q <= 1'b1;
    else if (gnt1) prio_q <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 32'd0;
      grant_cnt1 <= 32'd0;
    end else begin
      if (gnt0) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (gnt1) grant_cnt1 <= grant_cnt1 + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_alu_arb.sv
// Directed self-checking bench for ysyx_24100006_alu_arb; a small ALU model closes the ALU loop.
// Expectations follow YSYX_24100006_ALU_ARB_FIXED_PRI_EN when it is defined.
module tb_ysyx_24100006_alu_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rs_data, req0_rt_data, req1_rs_data, req1_rt_data;
  logic [3:0]  req0_aluop, req1_aluop;
  logic [31:0] alu_rs_data, alu_rt_data, alu_result;
  logic [3:0]  alu_aluop;
  logic        alu_of, alu_cf, alu_zf;
  logic        resp_valid, resp_id, resp_of, resp_cf, resp_zf, resp_ready;
  logic [31:0] resp_result, grant_cnt0, grant_cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24100006_alu_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rs_data(req0_rs_data), .req0_rt_data(req0_rt_data), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rs_data(req1_rs_data), .req1_rt_data(req1_rt_data), .req1_aluop(req1_aluop),
    .alu_rs_data(alu_rs_data), .alu_rt_data(alu_rt_data), .alu_aluop(alu_aluop),
    .alu_result(alu_result), .alu_of(alu_of), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_of(resp_of), .resp_cf(resp_cf), .resp_zf(resp_zf), .resp_ready(resp_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Opcode 0000 = add, 0001 = subtract; anything else passes rs through.
  always_comb begin
    logic [32:0] wide;
    wide = {1'b0, alu_rs_data};
    alu_of = 1'b0;
    case (alu_aluop)
      4'b0000: begin
        wide   = {1'b0, alu_rs_data} + {1'b0, alu_rt_data};
        alu_of = (alu_rs_data[31] == alu_rt_data[31]) && (wide[31] != alu_rs_data[31]);
      end
      4'b0001: begin
        wide   = {1'b0, alu_rs_data} - {1'b0, alu_rt_data};
        alu_of = (alu_rs_data[31] != alu_rt_data[31]) && (wide[31] != alu_rs_data[31]);
      end
      default: wide = {1'b0, alu_rs_data};
    endcase
    alu_result = wide[31:0];
    alu_cf     = wide[32];
    alu_zf     = (wide[31:0] == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held_result;
  logic        held_id;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_rs_data = 32'd0; req0_rt_data = 32'd0; req0_aluop = 4'd0;
    req1_rs_data = 32'd0; req1_rt_data = 32'd0; req1_aluop = 4'd0;
    resp_ready = 1'b1;
    tick();
    tick();

    // Reset state, including ready held low while a request is pending.
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_cnt0", grant_cnt0, 32'd0);
    check("rst_cnt1", grant_cnt1, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);

    // Single request: 5 + 3.
    reset = 1'b0;
    req0_rs_data = 32'd5; req0_rt_data = 32'd3; req0_aluop = 4'b0000;
    #1;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_alu_rs", alu_rs_data, 32'd5);
    tick();
    req0_valid = 1'b0;
    check("single_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("single_resp_id", {31'd0, resp_id}, 32'd0);
    check("single_result", resp_result, 32'd8);
    check("single_zf", {31'd0, resp_zf}, 32'd0);
    check("single_cnt0", grant_cnt0, 32'd1);
    tick();
    check("single_drain_empty", {31'd0, resp_valid}, 32'd0);

    // Reset again so the conflict starts with port 0 favoured.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_rs_data = 32'd7; req0_rt_data = 32'd7; req0_aluop = 4'b0001;
    req1_valid = 1'b1; req1_rs_data = 32'd1; req1_rt_data = 32'd1; req1_aluop = 4'b0000;
    #1;
    check("conf_c1_ready0", {31'd0, req0_ready}, 32'd1);
    check("conf_c1_ready1", {31'd0, req1_ready}, 32'd0);
    check("conf_c1_aluop", {28'd0, alu_aluop}, 32'd1);
    tick();
    check("conf_r1_id", {31'd0, resp_id}, 32'd0);
    check("conf_r1_result", resp_result, 32'd0);
    check("conf_r1_zf", {31'd0, resp_zf}, 32'd1);
`ifdef YSYX_24100006_ALU_ARB_FIXED_PRI_EN
    check("conf_c2_ready0", {31'd0, req0_ready}, 32'd1);
    check("conf_c2_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("fix_r2_id", {31'd0, resp_id}, 32'd0);
    tick();
    check("fix_r3_id", {31'd0, resp_id}, 32'd0);
    tick();
    check("fix_r4_id", {31'd0, resp_id}, 32'd0);
    check("fix_cnt0", grant_cnt0, 32'd4);
    check("fix_cnt1", grant_cnt1, 32'd0);
`else
    check("conf_c2_ready0", {31'd0, req0_ready}, 32'd0);
    check("conf_c2_ready1", {31'd0, req1_ready}, 32'd1);
    check("conf_c2_alu_rs", alu_rs_data, 32'd1);
    tick();
    check("rr_r2_id", {31'd0, resp_id}, 32'd1);
    check("rr_r2_result", resp_result, 32'd2);
    check("rr_r2_zf", {31'd0, resp_zf}, 32'd0);
    tick();
    check("rr_r3_id", {31'd0, resp_id}, 32'd0);
    tick();
    check("rr_r4_id", {31'd0, resp_id}, 32'd1);
    check("rr_cnt0", grant_cnt0, 32'd2);
    check("rr_cnt1", grant_cnt1, 32'd2);
`endif

    // Backpressure for three cycles with both requesters still valid.
    held_result = resp_result;
    held_id     = resp_id;
    resp_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_result_stable", resp_result, held_result);
      check("bp_id_stable", {31'd0, resp_id}, {31'd0, held_id});
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    check("bp_newgrant_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_newgrant_id", {31'd0, resp_id}, 32'd0);
    check("bp_newgrant_result", resp_result, 32'd0);
`ifdef YSYX_24100006_ALU_ARB_FIXED_PRI_EN
    check("bp_cnt0", grant_cnt0, 32'd5);
`else
    check("bp_cnt0", grant_cnt0, 32'd3);
`endif

    // Reset while the slot is FULL.
    req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_result", resp_result, 32'd0);
    check("midrst_cnt0", grant_cnt0, 32'd0);
    check("midrst_cnt1", grant_cnt1, 32'd0);
    reset = 1'b0;
    req0_valid = 1'b0;
    tick();

    // Counter wrap on port 0.
    force dut.grant_cnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.grant_cnt0;
    check("wrap_preload", grant_cnt0, 32'hFFFF_FFFF);
    req0_valid = 1'b1; req0_rs_data = 32'd5; req0_rt_data = 32'd3; req0_aluop = 4'b0000;
    tick();
    req0_valid = 1'b0;
    check("wrap_cnt0", grant_cnt0, 32'd0);
    check("wrap_cnt1", grant_cnt1, 32'd0);
    check("wrap_result", resp_result, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
